// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM write-port scheduler.
// Coordinate/data widths and the fill FSM encoding.
package vram_pkg;

    localparam int XW           = 7;
    localparam int DW           = 4;
    localparam int ADDR_W       = 2 * XW;
    localparam int MAX_HOST_RUN = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_LAST,
        ST_EMPTY
    } state_t;

endpackage

// File: rtl/vram_rect_walker.sv
// Rectangle cursor for the fill engine.
// Clips the command to the screen and steps raster order.
module vram_rect_walker
    import vram_pkg::*;
#(
    parameter int XW = vram_pkg::XW
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic          load,
    input  logic          step,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] y0,
    input  logic [XW:0]   w,
    input  logic [XW:0]   h,
    output logic [XW-1:0] cx,
    output logic [XW-1:0] cy,
    output logic          last
);

    localparam logic [XW+1:0] SPAN = (XW+2)'(1) << XW;

    logic [XW+1:0] xsum;
    logic [XW+1:0] ysum;
    logic [XW-1:0] xe_n;
    logic [XW-1:0] ye_n;
    logic [XW-1:0] xs;
    logic [XW-1:0] xe;
    logic [XW-1:0] ye;

    // Sums carry an extra bit so a far-right rectangle clamps instead of wrapping.
    assign xsum = {2'b00, x0} + {1'b0, w};
    assign ysum = {2'b00, y0} + {1'b0, h};
    assign xe_n = (xsum > SPAN) ? '1 : XW'(xsum - 1'b1);
    assign ye_n = (ysum > SPAN) ? '1 : XW'(ysum - 1'b1);

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            cx <= '0;
            cy <= '0;
            xs <= '0;
            xe <= '0;
            ye <= '0;
        end else if (load) begin
            cx <= x0;
            cy <= y0;
            xs <= x0;
            xe <= xe_n;
            ye <= ye_n;
        end else if (step) begin
            if (cx == xe) begin
                cx <= xs;
                cy <= cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

    assign last = (cx == xe) && (cy == ye);

endmodule

// File: rtl/vram_fill_ctrl.sv
// VRAM write-port scheduler: host pixel writes share the
// single port with a clipped rectangle-fill engine.
module vram_fill_ctrl
    import vram_pkg::*;
#(
    parameter int XW           = vram_pkg::XW,
    parameter int DW           = vram_pkg::DW,
    parameter int MAX_HOST_RUN = vram_pkg::MAX_HOST_RUN
) (
    input  logic            CLK,
    input  logic            RST_X,
    input  logic            CMD_VALID,
    output logic            CMD_READY,
    input  logic [XW-1:0]   CMD_X0,
    input  logic [XW-1:0]   CMD_Y0,
    input  logic [XW:0]     CMD_W,
    input  logic [XW:0]     CMD_H,
    input  logic [DW-1:0]   CMD_COLOR,
    input  logic            HOST_VALID,
    output logic            HOST_READY,
    input  logic [2*XW-1:0] HOST_ADDR,
    input  logic [DW-1:0]   HOST_DATA,
    output logic            BUSY,
    output logic            DONE,
    output logic [2*XW-1:0] VRAM_ADDR,
    output logic [DW-1:0]   VRAM_DATA,
    output logic            VRAM_WE
);

    localparam int RW = $clog2(MAX_HOST_RUN + 1);

    state_t          state;
    logic [RW-1:0]   run;
    logic [DW-1:0]   color;
    logic [XW-1:0]   cx;
    logic [XW-1:0]   cy;
    logic            fill_last;
    logic            in_fill;
    logic            host_gnt;
    logic            fill_gnt;
    logic            cmd_acc;
    logic            cmd_empty;

    assign in_fill   = (state == ST_FILL);
    assign host_gnt  = HOST_VALID && (!in_fill || run < RW'(MAX_HOST_RUN));
    assign fill_gnt  = in_fill && !host_gnt;
    assign cmd_acc   = CMD_VALID && CMD_READY;
    assign cmd_empty = (CMD_W == '0) || (CMD_H == '0);

    assign HOST_READY = host_gnt;
    assign CMD_READY  = (state == ST_IDLE);
    assign BUSY       = (state != ST_IDLE);
    assign DONE       = (state == ST_LAST) || (state == ST_EMPTY);

    vram_rect_walker #(
        .XW (XW)
    ) u_walker (
        .CLK  (CLK),
        .RST_X(RST_X),
        .load (cmd_acc),
        .step (fill_gnt),
        .x0   (CMD_X0),
        .y0   (CMD_Y0),
        .w    (CMD_W),
        .h    (CMD_H),
        .cx   (cx),
        .cy   (cy),
        .last (fill_last)
    );

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state     <= ST_IDLE;
            run       <= '0;
            color     <= '0;
            VRAM_WE   <= 1'b0;
            VRAM_ADDR <= '0;
            VRAM_DATA <= '0;
        end else begin
            VRAM_WE <= host_gnt | fill_gnt;
            unique case (1'b1)
                host_gnt: begin
                    VRAM_ADDR <= HOST_ADDR;
                    VRAM_DATA <= HOST_DATA;
                end
                fill_gnt: begin
                    VRAM_ADDR <= {cy, cx};
                    VRAM_DATA <= color;
                end
                default: ;
            endcase
            case (state)
                ST_IDLE: begin
                    run <= '0;
                    if (cmd_acc) begin
                        color <= CMD_COLOR;
                        state <= cmd_empty ? ST_EMPTY : ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Host bursts are bounded so a pending fill always progresses.
                    if (host_gnt) begin
                        run <= run + 1'b1;
                    end else begin
                        run <= '0;
                        if (fill_last) state <= ST_LAST;
                    end
                end
                ST_LAST, ST_EMPTY: begin
                    run   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_fill_ctrl.sv
// Self-checking bench for vram_fill_ctrl: directed vector table,
// hand sequences and a pixel-queue reference model under random traffic.
module tb_vram_fill_ctrl;
    import vram_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_X;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [6:0]  CMD_X0;
    logic [6:0]  CMD_Y0;
    logic [7:0]  CMD_W;
    logic [7:0]  CMD_H;
    logic [3:0]  CMD_COLOR;
    logic        HOST_VALID;
    logic        HOST_READY;
    logic [13:0] HOST_ADDR;
    logic [3:0]  HOST_DATA;
    logic        BUSY;
    logic        DONE;
    logic [13:0] VRAM_ADDR;
    logic [3:0]  VRAM_DATA;
    logic        VRAM_WE;

    always #5 CLK = ~CLK;

    vram_fill_ctrl dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_X0    (CMD_X0),
        .CMD_Y0    (CMD_Y0),
        .CMD_W     (CMD_W),
        .CMD_H     (CMD_H),
        .CMD_COLOR (CMD_COLOR),
        .HOST_VALID(HOST_VALID),
        .HOST_READY(HOST_READY),
        .HOST_ADDR (HOST_ADDR),
        .HOST_DATA (HOST_DATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .VRAM_ADDR (VRAM_ADDR),
        .VRAM_DATA (VRAM_DATA),
        .VRAM_WE   (VRAM_WE)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        hv;
        logic [13:0] ha;
        logic [3:0]  hd;
        logic        cv;
        logic [6:0]  x0;
        logic [6:0]  y0;
        logic [7:0]  w;
        logic [7:0]  h;
        logic [3:0]  c;
        logic        we;
        logic [13:0] addr;
        logic [3:0]  data;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(
        input logic hv, input logic [13:0] ha, input logic [3:0] hd,
        input logic cv, input logic [6:0] x0, input logic [6:0] y0,
        input logic [7:0] w, input logic [7:0] h, input logic [3:0] c,
        input logic we, input logic [13:0] addr, input logic [3:0] data,
        input logic done, input logic busy);
        vec_t r;
        r.hv = hv; r.ha = ha; r.hd = hd; r.cv = cv;
        r.x0 = x0; r.y0 = y0; r.w = w; r.h = h; r.c = c;
        r.we = we; r.addr = addr; r.data = data; r.done = done; r.busy = busy;
        return r;
    endfunction

    task automatic set_in(input logic hv, input logic [13:0] ha, input logic [3:0] hd,
                          input logic cv, input logic [6:0] x0, input logic [6:0] y0,
                          input logic [7:0] w, input logic [7:0] h, input logic [3:0] c);
        HOST_VALID = hv; HOST_ADDR = ha; HOST_DATA = hd;
        CMD_VALID = cv; CMD_X0 = x0; CMD_Y0 = y0;
        CMD_W = w; CMD_H = h; CMD_COLOR = c;
    endtask

    // Reference model: a queue of pixel addresses still to be written.
    logic [13:0] fq[$];
    logic [13:0] m_addr;
    logic [3:0]  m_data;
    logic [3:0]  mcolor;
    int          mrun;
    bit          m_busy;

    task automatic model_reset();
        fq.delete();
        m_addr = '0; m_data = '0; mcolor = '0; mrun = 0; m_busy = 0;
    endtask

    task automatic build(input int x0, input int y0, input int w, input int h);
        int xe, ye;
        xe = ((x0 + w) > 128 ? 128 : x0 + w) - 1;
        ye = ((y0 + h) > 128 ? 128 : y0 + h) - 1;
        if (w == 0 || h == 0) return;
        for (int y = y0; y <= ye; y++)
            for (int x = x0; x <= xe; x++)
                fq.push_back(14'(y * 128 + x));
    endtask

    task automatic tick_m(input logic hv, input logic [13:0] ha, input logic [3:0] hd,
                          input logic cv, input logic [6:0] x0, input logic [6:0] y0,
                          input logic [7:0] w, input logic [7:0] h, input logic [3:0] c);
        bit pend, hok, nwe, ndone;
        set_in(hv, ha, hd, cv, x0, y0, w, h, c);
        @(negedge CLK);
        pend = fq.size() > 0;
        hok = hv && (!pend || mrun < 4);
        chk("host_ready", 32'(HOST_READY), 32'(hok));
        chk("cmd_ready", 32'(CMD_READY), 32'(!m_busy));
        nwe = 0;
        ndone = 0;
        if (hok) begin
            nwe = 1; m_addr = ha; m_data = hd;
        end else if (pend) begin
            nwe = 1; m_addr = fq.pop_front(); m_data = mcolor;
            if (fq.size() == 0) ndone = 1;
        end
        mrun = (pend && hok) ? mrun + 1 : 0;
        if (!m_busy && cv) begin
            mcolor = c;
            build(x0, y0, w, h);
            if (w == 0 || h == 0) ndone = 1;
        end
        m_busy = (fq.size() > 0) || ndone;
        @(posedge CLK);
        #1;
        chk("m_we", 32'(VRAM_WE), 32'(nwe));
        chk("m_addr", 32'(VRAM_ADDR), 32'(m_addr));
        chk("m_data", 32'(VRAM_DATA), 32'(m_data));
        chk("m_done", 32'(DONE), 32'(ndone));
        chk("m_busy", 32'(BUSY), 32'(m_busy));
    endtask

    task automatic do_reset();
        RST_X = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_X = 1'b1;
        @(posedge CLK);
        #1;
        model_reset();
    endtask

    initial begin
        int done_at;
        // Directed vectors: host writes, fill, clip, empty, host+accept.
        vt.push_back(v(1, 14'h0005, 4'h1, 0, 0, 0, 0, 0, 0, 1, 14'h0005, 4'h1, 0, 0));
        vt.push_back(v(1, 14'h0006, 4'h2, 0, 0, 0, 0, 0, 0, 1, 14'h0006, 4'h2, 0, 0));
        vt.push_back(v(1, 14'h3FFF, 4'hF, 0, 0, 0, 0, 0, 0, 1, 14'h3FFF, 4'hF, 0, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 14'h3FFF, 4'hF, 0, 0));
        vt.push_back(v(0, 0, 0, 1, 2, 3, 3, 2, 7, 0, 14'h3FFF, 4'hF, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14'h0182, 4'h7, 0, 1));
        vt.push_back(v(0, 0, 0, 1, 0, 0, 1, 1, 9, 1, 14'h0183, 4'h7, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14'h0184, 4'h7, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14'h0202, 4'h7, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14'h0203, 4'h7, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14'h0204, 4'h7, 1, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 14'h0204, 4'h7, 0, 0));
        vt.push_back(v(0, 0, 0, 1, 126, 127, 5, 4, 5, 0, 14'h0204, 4'h7, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14'h3FFE, 4'h5, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14'h3FFF, 4'h5, 1, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 14'h3FFF, 4'h5, 0, 0));
        vt.push_back(v(0, 0, 0, 1, 5, 5, 0, 9, 2, 0, 14'h3FFF, 4'h5, 1, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 14'h3FFF, 4'h5, 0, 0));
        vt.push_back(v(1, 14'h0100, 4'h9, 1, 0, 0, 1, 1, 4, 1, 14'h0100, 4'h9, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14'h0000, 4'h4, 1, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 14'h0000, 4'h4, 0, 0));

        RST_X = 1'b0;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_we", 32'(VRAM_WE), 0);
        chk("rst_addr", 32'(VRAM_ADDR), 0);
        chk("rst_data", 32'(VRAM_DATA), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_cmd_ready", 32'(CMD_READY), 1);
        chk("rst_host_ready_v1", 32'(HOST_READY), 1);
        HOST_VALID = 1'b0;
        #1;
        chk("rst_host_ready_v0", 32'(HOST_READY), 0);
        do_reset();

        foreach (vt[i]) begin
            set_in(vt[i].hv, vt[i].ha, vt[i].hd, vt[i].cv,
                   vt[i].x0, vt[i].y0, vt[i].w, vt[i].h, vt[i].c);
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_we", i), 32'(VRAM_WE), 32'(vt[i].we));
            chk($sformatf("v%0d_addr", i), 32'(VRAM_ADDR), 32'(vt[i].addr));
            chk($sformatf("v%0d_data", i), 32'(VRAM_DATA), 32'(vt[i].data));
            chk($sformatf("v%0d_done", i), 32'(DONE), 32'(vt[i].done));
            chk($sformatf("v%0d_busy", i), 32'(BUSY), 32'(vt[i].busy));
            chk($sformatf("v%0d_cmd_ready", i), 32'(CMD_READY), 32'(!vt[i].busy));
        end

        // Host hammering a pending fill: HHHHF per pixel, 8 pixels.
        do_reset();
        tick_m(1, 14'($urandom), 4'($urandom), 1, 0, 0, 4, 2, 3);
        done_at = -1;
        for (int i = 1; i <= 100; i++) begin
            tick_m(1, 14'($urandom), 4'($urandom), 0, 0, 0, 0, 0, 0);
            if (DONE && done_at < 0) done_at = i;
            if (!BUSY) break;
        end
        chk("hostrun_done_cycle", 32'(done_at), 40);

        // Random mixed traffic against the pixel-queue model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] w;
            w = ($urandom % 8 == 0) ? 8'd128 : 8'($urandom_range(0, 5));
            tick_m(($urandom % 10) < 6, 14'($urandom), 4'($urandom),
                   ($urandom % 4) == 0, 7'($urandom), 7'($urandom),
                   w, 8'($urandom_range(0, 4)), 4'($urandom));
        end

        // Reset in the middle of a fill, then a fresh command.
        do_reset();
        set_in(0, 0, 0, 1, 10, 10, 10, 10, 8);
        @(posedge CLK);
        #1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) @(posedge CLK);
        #1;
        chk("mid_busy", 32'(BUSY), 1);
        chk("mid_we", 32'(VRAM_WE), 1);
        #2;
        RST_X = 1'b0;
        #1;
        chk("abort_we", 32'(VRAM_WE), 0);
        chk("abort_busy", 32'(BUSY), 0);
        chk("abort_done", 32'(DONE), 0);
        chk("abort_addr", 32'(VRAM_ADDR), 0);
        chk("abort_cmd_ready", 32'(CMD_READY), 1);
        @(negedge CLK);
        RST_X = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_done", 32'(DONE), 0);
        set_in(0, 0, 0, 1, 1, 1, 1, 1, 6);
        @(posedge CLK);
        #1;
        chk("new_cmd_busy", 32'(BUSY), 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        chk("new_cmd_we", 32'(VRAM_WE), 1);
        chk("new_cmd_addr", 32'(VRAM_ADDR), 32'h81);
        chk("new_cmd_data", 32'(VRAM_DATA), 6);
        chk("new_cmd_done", 32'(DONE), 1);
        @(posedge CLK);
        #1;
        chk("new_cmd_idle", 32'(BUSY), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
